// File: rtl/clkdiv_multi.sv
// clkdiv_multi: NCH independent programmable clock dividers.
// Each channel counts CLK cycles up to its active divisor and emits a
// one-cycle TICK, a toggling SQ and, in one-shot mode, a BUSY flag.
// Divisor writes go to a shadow register and reach the active divisor
// only at terminal count or while the channel is idle/armed, so a period
// change never produces a short or long period.
// Optional build macro CLKDIV_TICKCOUNT_EN adds TICK_TOTAL, a 16-bit
// wrapping per-channel count of TICK pulses.
module clkdiv_multi #(
  parameter int NCH         = 4,
  parameter int W           = 30,
  parameter int DEFAULT_DIV = 1249999
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [NCH-1:0] EN,
  input  logic [NCH-1:0] MODE,
  input  logic [NCH-1:0] START,
  input  logic [NCH-1:0] LOAD,
  input  logic [W-1:0]   DIV_IN,
  output logic [NCH-1:0] TICK,
  output logic [NCH-1:0] SQ,
  output logic [NCH-1:0] BUSY
`ifdef CLKDIV_TICKCOUNT_EN
  ,
  output logic [NCH*16-1:0] TICK_TOTAL
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_ARMED = 2'd2,
    ST_SHOT  = 2'd3
  } state_t;

  localparam logic [W-1:0] DIV_RST = W'(DEFAULT_DIV);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t       state;
    logic [W-1:0] cnt;
    logic [W-1:0] div_act;
    logic [W-1:0] div_sh;
    logic         tick_q;
    logic         sq_q;
    logic         busy_q;
    logic         fire;
    logic [W-1:0] div_at_tc;

    // Terminal count of an active count; EN low aborts it before it can fire.
    assign fire = EN[i] && ((state == ST_RUN) || (state == ST_SHOT)) && (cnt == div_act);
    // A LOAD landing on terminal count bypasses the shadow so it applies at once.
    assign div_at_tc = LOAD[i] ? DIV_IN : div_sh;

    // Channel state machine, counter, divisor pipeline and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        state   <= ST_IDLE;
        cnt     <= '0;
        div_act <= DIV_RST;
        div_sh  <= DIV_RST;
        tick_q  <= 1'b0;
        sq_q    <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        // NOTE: non-blocking assignments throughout, so every read below sees
        // the pre-edge value regardless of statement order.
        tick_q <= fire;
        if (fire) sq_q <= ~sq_q;
        if (LOAD[i]) div_sh <= DIV_IN;

        if (!EN[i]) begin
          state  <= ST_IDLE;
          cnt    <= '0;
          busy_q <= 1'b0;
          if (state == ST_IDLE) div_act <= div_sh;
        end else begin
          case (state)
            ST_IDLE: begin
              cnt     <= '0;
              div_act <= div_sh;
              state   <= MODE[i] ? ST_ARMED : ST_RUN;
            end
            ST_RUN: begin
              if (fire) begin
                cnt     <= '0;
                div_act <= div_at_tc;
                if (MODE[i]) state <= ST_ARMED;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
            ST_ARMED: begin
              cnt     <= '0;
              busy_q  <= 1'b0;
              div_act <= div_sh;
              if (!MODE[i]) begin
                state <= ST_RUN;
              end else if (START[i]) begin
                state  <= ST_SHOT;
                busy_q <= 1'b1;
              end
            end
            ST_SHOT: begin
              if (fire) begin
                cnt     <= '0;
                div_act <= div_at_tc;
                busy_q  <= 1'b0;
                state   <= ST_ARMED;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
            default: state <= ST_IDLE;
          endcase
        end
      end
    end

    assign TICK[i] = tick_q;
    assign SQ[i]   = sq_q;
    assign BUSY[i] = busy_q;

`ifdef CLKDIV_TICKCOUNT_EN
    logic [15:0] tick_total_q;

    // Wrapping tick counter, advanced on the same edge that raises TICK.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        tick_total_q <= '0;
      end else if (!EN[i]) begin
        tick_total_q <= '0;
      end else if (fire) begin
        tick_total_q <= tick_total_q + 16'd1;
      end
    end

    assign TICK_TOTAL[16*i +: 16] = tick_total_q;
`else
    // Default build: no per-channel tick counter.
`endif
  end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Directed testbench for clkdiv_multi (NCH=4, W=30, DEFAULT_DIV=4).
// Inputs are driven and outputs sampled on the falling edge of CLK.
module tb_clkdiv_multi;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  EN, MODE, START, LOAD;
  logic [29:0] DIV_IN;
  logic [3:0]  TICK, SQ, BUSY;
`ifdef CLKDIV_TICKCOUNT_EN
  logic [63:0] TICK_TOTAL;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] exp_sq;

  typedef struct {
    int          ch;
    logic [29:0] div;
    int          first;
    int          per;
  } vec_t;

  vec_t vecs[5];

  clkdiv_multi #(.NCH(4), .W(30), .DEFAULT_DIV(4)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .EN    (EN),
    .MODE  (MODE),
    .START (START),
    .LOAD  (LOAD),
    .DIV_IN(DIV_IN),
    .TICK  (TICK),
    .SQ    (SQ),
    .BUSY  (BUSY)
`ifdef CLKDIV_TICKCOUNT_EN
    ,
    .TICK_TOTAL(TICK_TOTAL)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Program a divisor while idle and enter RUN; returns one negedge after the entry edge.
  task automatic start_cont(input int ch, input logic [29:0] div);
    EN[ch] = 1'b0;
    MODE[ch] = 1'b0;
    @(negedge CLK);
    LOAD[ch] = 1'b1;
    DIV_IN = div;
    @(negedge CLK);
    LOAD[ch] = 1'b0;
    EN[ch] = 1'b1;
    @(negedge CLK);
  endtask

  // Count cycles to the next TICK on ch; optionally pulse LOAD at cycle load_at.
  task automatic run_period(input int ch, input int exp, input int load_at,
                            input logic [29:0] load_val, input string name);
    int  n;
    bit  hit;
    n = 0;
    hit = 0;
    while (!hit && n < 200) begin
      @(negedge CLK);
      n++;
      if (TICK[ch]) hit = 1;
      LOAD[ch] = (n == load_at);
      DIV_IN = load_val;
    end
    LOAD[ch] = 1'b0;
    check(name, n, exp);
    if (hit) exp_sq[ch] = ~exp_sq[ch];
    check({name, "_sq"}, SQ[ch], exp_sq[ch]);
  endtask

  // One-shot on ch with the given divisor; optional retrigger START at cycle retrig.
  task automatic oneshot(input int ch, input logic [29:0] div, input int exp_busy,
                         input int exp_tick_at, input int retrig, input string name);
    int ticks, tick_k, busy_n;
    EN[ch] = 1'b0;
    MODE[ch] = 1'b1;
    @(negedge CLK);
    LOAD[ch] = 1'b1;
    DIV_IN = div;
    @(negedge CLK);
    LOAD[ch] = 1'b0;
    EN[ch] = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check({name, "_armed_busy"}, BUSY[ch], 1'b0);
    START[ch] = 1'b1;
    ticks = 0;
    tick_k = 0;
    busy_n = 0;
    for (int k = 1; k <= exp_tick_at + 6; k++) begin
      @(negedge CLK);
      if (TICK[ch]) begin
        ticks++;
        tick_k = k;
      end
      if (BUSY[ch]) busy_n++;
      START[ch] = (retrig != 0) && (k == retrig);
    end
    START[ch] = 1'b0;
    check({name, "_ticks"}, ticks, 1);
    check({name, "_tick_at"}, tick_k, exp_tick_at);
    check({name, "_busy_cycles"}, busy_n, exp_busy);
    check({name, "_busy_end"}, BUSY[ch], 1'b0);
    if (ticks[0]) exp_sq[ch] = ~exp_sq[ch];
    check({name, "_sq"}, SQ[ch], exp_sq[ch]);
    EN[ch] = 1'b0;
    MODE[ch] = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    int ticks, hi, tog;
    logic prev;

    vecs[0] = '{ch: 0, div: 30'd9, first: 10, per: 10};
    vecs[1] = '{ch: 1, div: 30'd2, first: 3,  per: 3};
    vecs[2] = '{ch: 2, div: 30'd1, first: 2,  per: 2};
    vecs[3] = '{ch: 3, div: 30'd5, first: 6,  per: 6};
    vecs[4] = '{ch: 0, div: 30'd0, first: 1,  per: 1};

    RST = 1'b1;
    EN = '0;
    MODE = '0;
    START = '0;
    LOAD = '0;
    DIV_IN = '0;
    exp_sq = '0;
    repeat (2) @(negedge CLK);
    check("reset_tick", TICK, 4'h0);
    check("reset_sq", SQ, 4'h0);
    check("reset_busy", BUSY, 4'h0);

    // Default divisor 4 on all channels: TICK every 5 cycles.
    RST = 1'b0;
    @(negedge CLK);
    EN = 4'hF;
    @(negedge CLK);
    for (int k = 1; k <= 7; k++) begin
      logic [3:0] exp_t;
      @(negedge CLK);
      exp_t = (k % 5 == 0) ? 4'hF : 4'h0;
      exp_sq = exp_sq ^ exp_t;
      check($sformatf("default_tick_%0d", k), TICK, exp_t);
      check($sformatf("default_sq_%0d", k), SQ, exp_sq);
    end

    // Asynchronous reset in mid-period, well away from any clock edge.
    #1 RST = 1'b1;
    #1;
    check("async_rst_tick", TICK, 4'h0);
    check("async_rst_sq", SQ, 4'h0);
    check("async_rst_busy", BUSY, 4'h0);
    exp_sq = '0;
    EN = '0;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // Continuous-mode vectors: first TICK and steady period.
    for (int v = 0; v < 5; v++) begin
      start_cont(vecs[v].ch, vecs[v].div);
      run_period(vecs[v].ch, vecs[v].first, -1, '0, $sformatf("vec%0d_first", v));
      run_period(vecs[v].ch, vecs[v].per, -1, '0, $sformatf("vec%0d_period", v));
      EN[vecs[v].ch] = 1'b0;
    end

    // Glitch-free reload and terminal-count bypass on ch0.
    start_cont(0, 30'd9);
    run_period(0, 10, -1, '0, "reload_first");
    run_period(0, 10, 3, 30'd2, "reload_current");
    run_period(0, 3, -1, '0, "reload_new1");
    run_period(0, 3, -1, '0, "reload_new2");
    run_period(0, 3, 2, 30'd4, "bypass_at_tc");
    run_period(0, 5, -1, '0, "bypass_new");
    EN[0] = 1'b0;
    @(negedge CLK);

    // One-shot, div 6, with a retrigger attempt while busy.
    oneshot(1, 30'd6, 7, 8, 3, "shot6");

    // Abort mid-count and re-enable.
    start_cont(2, 30'd7);
    ticks = 0;
    for (int n = 1; n <= 17; n++) begin
      @(negedge CLK);
      if (TICK[2]) ticks++;
      if (n == 5) EN[2] = 1'b0;
    end
    check("abort_no_tick", ticks, 0);
    EN[2] = 1'b1;
    @(negedge CLK);
    run_period(2, 8, -1, '0, "abort_reenable");
    EN[2] = 1'b0;
    @(negedge CLK);

    // Divisor 0 continuous: TICK stuck high, SQ toggles every cycle.
    start_cont(3, 30'd0);
    hi = 0;
    tog = 0;
    prev = SQ[3];
    for (int n = 1; n <= 8; n++) begin
      @(negedge CLK);
      if (TICK[3]) hi++;
      if (SQ[3] !== prev) tog++;
      prev = SQ[3];
    end
    EN[3] = 1'b0;
    check("div0_tick_high", hi, 8);
    check("div0_sq_toggles", tog, 8);

`ifdef CLKDIV_TICKCOUNT_EN
    // 65537 ticks wrap the 16-bit total to 1; EN low clears it.
    start_cont(3, 30'd0);
    for (int n = 1; n <= 65537; n++) @(negedge CLK);
    EN[3] = 1'b0;
    exp_sq[3] = ~exp_sq[3];
    check("tick_total_wrap", TICK_TOTAL[63:48], 16'd1);
    @(negedge CLK);
    check("tick_total_clear", TICK_TOTAL[63:48], 16'd0);
`endif
    @(negedge CLK);

    // One-shot with divisor 0: TICK and BUSY drop one cycle after START.
    oneshot(3, 30'd0, 1, 2, 0, "shot0");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clkdiv_multi.md
Name: clkdiv_multi

Overview:
Parametrised multi-channel successor to the fixed 800-series tick divider. Each channel divides CLK by a runtime-programmable value and produces a one-cycle TICK strobe and a toggling SQ output. Each channel runs either continuously or as a one-shot timer. Used as the common timebase for the motor PWM, ultrasonic ping timing and UART-side timeouts.

Parameters:
NCH, 4, number of independent channels
W, 30, divisor/counter width in bits
DEFAULT_DIV, 1249999, reset value of every channel's divisor (period = DEFAULT_DIV+1 cycles)

Ports:
CLK  input  1  system clock
RST  input  1  reset, asynchronous, active-high
EN  input  NCH  per-channel enable; low holds the channel idle
MODE  input  NCH  per-channel mode: 0 = continuous, 1 = one-shot
START  input  NCH  per-channel one-shot trigger; single-cycle pulse; ignored in continuous mode
LOAD  input  NCH  per-channel divisor write strobe
DIV_IN  input  W  divisor value written by LOAD (shared bus)
TICK  output  NCH  one-cycle strobe at each terminal count, registered
SQ  output  NCH  toggles at each terminal count
BUSY  output  NCH  one-shot channel is counting

Behaviour:
- Reset, asynchronous, per channel:
  - cnt = 0, div_act = div_sh = DEFAULT_DIV
  - TICK = 0, SQ = 0, BUSY = 0, state = IDLE
- Divisor handling:
  - LOAD[i] writes DIV_IN into div_sh[i] at the next edge.
  - div_act[i] takes div_sh[i] only at terminal count (cnt == div_act), or on any cycle the channel is IDLE or ARMED.
  - This makes period changes glitch-free.
  - If LOAD[i] and terminal count coincide, div_act takes DIV_IN directly (bypass).
- Period: TICK fires every div_act+1 cycles.
  - div_act = 0: TICK held high every cycle in continuous mode; SQ toggles every cycle.
- TICK timing: registered. TICK is high in the cycle after the one where cnt == div_act, and never high for two consecutive cycles unless div_act = 0.
- SQ: toggles in the same cycle TICK rises, so its period is 2*(div_act+1).
- Per-channel state machine:
  - IDLE: entered whenever EN = 0, from any state, next edge.
    - cnt = 0, TICK = 0, BUSY = 0, SQ holds its value.
    - Exit when EN = 1: MODE = 0 → RUN; MODE = 1 → ARMED.
  - RUN (continuous): cnt increments and wraps to 0 at div_act; TICK as above.
    - MODE changing to 1 → ARMED at the next wrap.
  - ARMED (one-shot idle): cnt = 0, BUSY = 0.
    - START = 1 → SHOT, with BUSY = 1 from the next cycle.
    - MODE changing to 0 → RUN.
  - SHOT: cnt counts 0..div_act. At terminal count: TICK pulses once, BUSY drops with the TICK, state → ARMED.
    - START during SHOT is ignored; no retrigger.
- First TICK after entering RUN/SHOT: exactly div_act+1 cycles after the entry edge.
- EN deasserted mid-count aborts the count: no TICK, cnt = 0.
- Channels are fully independent; no cross-channel interaction.
- Counter arithmetic is W-bit unsigned; cnt never exceeds div_act, so there is no overflow wrap.

Optional Feature:
Macro: CLKDIV_TICKCOUNT_EN
- Defined:
  - Adds output TICK_TOTAL [NCH*16], channel i in bits [16i+15:16i].
  - Each field is a 16-bit wrapping count of TICK pulses; 0xFFFF+1 → 0.
  - Cleared by RST and by EN[i] falling.
- Undefined: port and counters absent; all other behaviour identical.

Test Plan:
- Reset/default: override DEFAULT_DIV = 4, EN = 1111, MODE = 0 → TICK on every channel every 5 cycles, first at cycle 5 after EN; SQ period 10. Assert RST mid-count → all outputs 0 immediately, without waiting for a clock edge.
- Glitch-free reload: ch0 running div = 9; LOAD DIV_IN = 2 at cnt = 3 → the current period completes at 10 cycles, then 3-cycle periods. LOAD coinciding with terminal count → the new period applies immediately.
- One-shot: ch1 MODE = 1, div = 6, START pulse → BUSY high 7 cycles, single TICK at the end, then ARMED. Second START while BUSY → ignored; TICK count = 1.
- Abort: ch2 running div = 7, drop EN at cnt = 5 → no TICK, cnt = 0. Re-enable → first TICK 8 cycles later.
- Boundary div = 0: ch3 continuous → TICK constantly high, SQ toggles every cycle. One-shot with div = 0 → TICK and BUSY-drop 1 cycle after START.
- CLKDIV_TICKCOUNT_EN: div = 0 for 65537 cycles → TICK_TOTAL wraps to 1. Drop EN → TICK_TOTAL = 0.
